// File: rtl/l2_cache_pkg.sv
// Shared types and default geometry for the L2 cache responder.
// Derived widths here describe the default configuration only.
package l2_cache_pkg;

    localparam int unsigned ADDR_W              = 32;
    localparam int unsigned CNT_W               = 20;
    localparam int unsigned DEF_WAY             = 4;
    localparam int unsigned DEF_BLOCK_SIZE_BYTE = 16;
    localparam int unsigned DEF_CACHE_SIZE_BYTE = 64 * 1024;

    localparam int unsigned OFFSET_W = $clog2(DEF_BLOCK_SIZE_BYTE);
    localparam int unsigned SETS     = DEF_CACHE_SIZE_BYTE / (DEF_BLOCK_SIZE_BYTE * DEF_WAY);
    localparam int unsigned INDEX_W  = $clog2(SETS);
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned WAY_W    = $clog2(DEF_WAY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_UPDATE,
        ST_RESP
    } l2_state_e;

endpackage

// File: rtl/l2_lru_shift.sv
// Combinational LRU-by-position reorder of one set: way 0 is MRU, way N-1 is LRU.
module l2_lru_shift
    import l2_cache_pkg::*;
#(
    parameter int unsigned way   = DEF_WAY,
    parameter int unsigned tag_w = TAG_W,
    parameter int unsigned way_w = WAY_W
) (
    input  logic [way-1:0][tag_w-1:0] set_tag,
    input  logic [way-1:0]            set_valid,
    input  logic                      hit,
    input  logic [way_w-1:0]          hit_way,
    input  logic [tag_w-1:0]          new_tag,
    output logic [way-1:0][tag_w-1:0] out_tag,
    output logic [way-1:0]            out_valid,
    output logic [tag_w-1:0]          victim_tag,
    output logic                      victim_valid
);

    always_comb begin
        out_tag      = set_tag;
        out_valid    = set_valid;
        victim_tag   = set_tag[way-1];
        victim_valid = set_valid[way-1];
        if (hit) begin
            for (int unsigned i = 1; i < way; i++) begin
                if (i <= 32'(hit_way)) begin
                    out_tag[i]   = set_tag[i-1];
                    out_valid[i] = set_valid[i-1];
                end
            end
            out_tag[0]   = set_tag[hit_way];
            out_valid[0] = 1'b1;
        end else begin
            for (int unsigned i = 1; i < way; i++) begin
                out_tag[i]   = set_tag[i-1];
                out_valid[i] = set_valid[i-1];
            end
            out_tag[0]   = new_tag;
            out_valid[0] = 1'b1;
        end
    end

endmodule

// File: rtl/l2_cache_responder.sv
// Inclusive set-associative L2 tag responder: looks up an L1 miss, updates
// true-LRU order, and reports the evicted line for L1 back-invalidation.
module l2_cache_responder
    import l2_cache_pkg::*;
#(
    parameter int unsigned way             = DEF_WAY,
    parameter int unsigned block_size_byte = DEF_BLOCK_SIZE_BYTE,
    parameter int unsigned cache_size_byte = DEF_CACHE_SIZE_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              find_start,
    input  logic [31:0]       req_addr,
    output logic              busy,
    output logic              L2_cache_hit,
    output logic              done_L2,
    output logic              back_invalidation,
    output logic [31:0]       back_invalidation_data,
    output logic [CNT_W-1:0]  cache_hit_count,
    output logic [CNT_W-1:0]  cache_miss_count
);

    localparam int unsigned OFF_W  = $clog2(block_size_byte);
    localparam int unsigned NSETS  = cache_size_byte / (block_size_byte * way);
    localparam int unsigned IDX_W  = $clog2(NSETS);
    localparam int unsigned TG_W   = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned WY_W   = $clog2(way);
    localparam int unsigned LINE_W = ADDR_W - OFF_W;

    l2_state_e state_q, state_d;

    logic [LINE_W-1:0]        line_q, line_d;
    logic                     hit_q, hit_d;
    logic [WY_W-1:0]          hit_way_q, hit_way_d;
    logic                     back_inv_q, back_inv_d;
    logic [31:0]              back_data_q, back_data_d;
    logic [CNT_W-1:0]         hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]         miss_cnt_q, miss_cnt_d;

    logic [way-1:0][TG_W-1:0] tag_mem [NSETS];
    logic [way-1:0]           valid_q [NSETS];

    logic [IDX_W-1:0]         index;
    logic [TG_W-1:0]          tag;
    logic [way-1:0][TG_W-1:0] set_tag, new_tag_set;
    logic [way-1:0]           set_valid, new_valid_set;
    logic [TG_W-1:0]          victim_tag;
    logic                     victim_valid;
    logic                     hit_now;
    logic [WY_W-1:0]          hit_way_now;
    logic                     offset_unused;

    assign offset_unused = ^req_addr[OFF_W-1:0];
    assign index     = line_q[IDX_W-1:0];
    assign tag       = line_q[LINE_W-1:IDX_W];
    assign set_tag   = tag_mem[index];
    assign set_valid = valid_q[index];

    always_comb begin
        hit_now     = 1'b0;
        hit_way_now = '0;
        for (int unsigned i = 0; i < way; i++) begin
            if (set_valid[i] && set_tag[i] == tag) begin
                hit_now     = 1'b1;
                hit_way_now = WY_W'(i);
            end
        end
    end

    l2_lru_shift #(
        .way   (way),
        .tag_w (TG_W),
        .way_w (WY_W)
    ) u_lru (
        .set_tag      (set_tag),
        .set_valid    (set_valid),
        .hit          (hit_q),
        .hit_way      (hit_way_q),
        .new_tag      (tag),
        .out_tag      (new_tag_set),
        .out_valid    (new_valid_set),
        .victim_tag   (victim_tag),
        .victim_valid (victim_valid)
    );

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        hit_d       = hit_q;
        hit_way_d   = hit_way_q;
        back_inv_d  = back_inv_q;
        back_data_d = back_data_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (find_start) begin
                    line_d      = req_addr[31:OFF_W];
                    hit_d       = 1'b0;
                    back_inv_d  = 1'b0;
                    back_data_d = '0;
                    state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                hit_d     = hit_now;
                hit_way_d = hit_way_now;
                if (hit_now) begin
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                end else begin
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                end
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (!hit_q && victim_valid) begin
                    back_inv_d  = 1'b1;
                    back_data_d = {victim_tag, index, {OFF_W{1'b0}}};
                end
                state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q      <= '0;
            hit_q       <= 1'b0;
            hit_way_q   <= '0;
            back_inv_q  <= 1'b0;
            back_data_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            for (int unsigned s = 0; s < NSETS; s++) valid_q[s] <= '0;
        end else begin
            line_q      <= line_d;
            hit_q       <= hit_d;
            hit_way_q   <= hit_way_d;
            back_inv_q  <= back_inv_d;
            back_data_q <= back_data_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            if (state_q == ST_UPDATE) valid_q[index] <= new_valid_set;
        end
    end

    // Tag storage carries no reset; valid_q alone decides whether a way is live.
    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_UPDATE) tag_mem[index] <= new_tag_set;
    end

    assign busy                   = (state_q != ST_IDLE);
    assign done_L2                = (state_q == ST_RESP);
    assign L2_cache_hit           = hit_q;
    assign back_invalidation      = back_inv_q;
    assign back_invalidation_data = back_data_q;
    assign cache_hit_count        = hit_cnt_q;
    assign cache_miss_count       = miss_cnt_q;

endmodule

// File: tb/tb_l2_cache_responder.sv
// Self-checking bench for l2_cache_responder: directed table, corner sequences,
// and random traffic against a move-to-front list model of each set.
module tb_l2_cache_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        find_start = 1'b0;
    logic [31:0] req_addr = '0;
    logic        busy, L2_cache_hit, done_L2, back_invalidation;
    logic [31:0] back_invalidation_data;
    logic [19:0] cache_hit_count, cache_miss_count;

    int checks = 0;
    int errors = 0;

    l2_cache_responder #(
        .way             (4),
        .block_size_byte (16),
        .cache_size_byte (64 * 1024)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .find_start             (find_start),
        .req_addr               (req_addr),
        .busy                   (busy),
        .L2_cache_hit           (L2_cache_hit),
        .done_L2                (done_L2),
        .back_invalidation      (back_invalidation),
        .back_invalidation_data (back_invalidation_data),
        .cache_hit_count        (cache_hit_count),
        .cache_miss_count       (cache_miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        find_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full request; returns the values observed while done_L2 is high.
    task automatic do_req(input logic [31:0] a, output logic hit, output logic bi,
                          output logic [31:0] bid, output logic [19:0] hc, output logic [19:0] mc);
        int k;
        @(negedge clk);
        find_start = 1'b1;
        req_addr   = a;
        @(negedge clk);
        find_start = 1'b0;
        req_addr   = $urandom;
        chk("busy_after_accept", 32'(busy), 32'd1);
        k = 0;
        while (!done_L2 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("done_latency", k, 2);
        chk("busy_at_done", 32'(busy), 32'd1);
        hit = L2_cache_hit;
        bi  = back_invalidation;
        bid = back_invalidation_data;
        hc  = cache_hit_count;
        mc  = cache_miss_count;
        @(negedge clk);
        chk("done_single_pulse", 32'(done_L2), 32'd0);
        chk("busy_cleared", 32'(busy), 32'd0);
        chk("bi_held", 32'(back_invalidation), 32'(bi));
        chk("bid_held", back_invalidation_data, bid);
        chk("hit_held", 32'(L2_cache_hit), 32'(hit));
    endtask

    // Reference: each set is an ordered list of tags, most recently used first.
    logic [17:0] mset [4][$];
    int unsigned m_hits, m_misses;

    task automatic model_clear();
        for (int s = 0; s < 4; s++) mset[s].delete();
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic model_access(input logic [31:0] a, output logic hit, output logic bi,
                                output logic [31:0] bid);
        int unsigned idx;
        logic [17:0] tg, victim;
        int pos;
        idx = a[13:4];
        tg  = a[31:14];
        pos = -1;
        bi  = 1'b0;
        bid = '0;
        for (int p = 0; p < mset[idx].size(); p++)
            if (mset[idx][p] == tg) pos = p;
        if (pos >= 0) begin
            hit = 1'b1;
            m_hits++;
            mset[idx].delete(pos);
        end else begin
            hit = 1'b0;
            m_misses++;
            if (mset[idx].size() == 4) begin
                victim = mset[idx].pop_back();
                bi  = 1'b1;
                bid = {victim, 10'(idx), 4'h0};
            end
        end
        mset[idx].push_front(tg);
    endtask

    typedef struct {
        bit          do_rst;
        logic [31:0] addr;
        logic        hit;
        logic        bi;
        logic [31:0] bid;
        logic [19:0] hc;
        logic [19:0] mc;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic        h, b;
        logic [31:0] d;
        logic [19:0] hc, mc;
        logic        mh, mb;
        logic [31:0] md;
        logic [31:0] a;
        int dones, doubles, prev;

        vecs[0]  = '{1'b0, 32'h0000_1230, 1'b0, 1'b0, 32'h0,         20'd0, 20'd1};
        vecs[1]  = '{1'b0, 32'h0000_1230, 1'b1, 1'b0, 32'h0,         20'd1, 20'd1};
        vecs[2]  = '{1'b0, 32'h0000_0010, 1'b0, 1'b0, 32'h0,         20'd1, 20'd2};
        vecs[3]  = '{1'b0, 32'h0000_4010, 1'b0, 1'b0, 32'h0,         20'd1, 20'd3};
        vecs[4]  = '{1'b0, 32'h0000_8010, 1'b0, 1'b0, 32'h0,         20'd1, 20'd4};
        vecs[5]  = '{1'b0, 32'h0000_C010, 1'b0, 1'b0, 32'h0,         20'd1, 20'd5};
        vecs[6]  = '{1'b0, 32'h0001_0010, 1'b0, 1'b1, 32'h0000_0010, 20'd1, 20'd6};
        vecs[7]  = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0,         20'd0, 20'd1};
        vecs[8]  = '{1'b0, 32'h0000_4010, 1'b0, 1'b0, 32'h0,         20'd0, 20'd2};
        vecs[9]  = '{1'b0, 32'h0000_8010, 1'b0, 1'b0, 32'h0,         20'd0, 20'd3};
        vecs[10] = '{1'b0, 32'h0000_C010, 1'b0, 1'b0, 32'h0,         20'd0, 20'd4};
        vecs[11] = '{1'b0, 32'h0000_0010, 1'b1, 1'b0, 32'h0,         20'd1, 20'd4};
        vecs[12] = '{1'b0, 32'h0001_0010, 1'b0, 1'b1, 32'h0000_4010, 20'd1, 20'd5};
        vecs[13] = '{1'b0, 32'h0000_4010, 1'b0, 1'b1, 32'h0000_8010, 20'd1, 20'd6};
        vecs[14] = '{1'b0, 32'h0000_8010, 1'b0, 1'b1, 32'h0000_C010, 20'd1, 20'd7};

        do_reset();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done_L2), 32'd0);
        chk("rst_hit", 32'(L2_cache_hit), 32'd0);
        chk("rst_bi", 32'(back_invalidation), 32'd0);
        chk("rst_bid", back_invalidation_data, 32'd0);
        chk("rst_hit_count", 32'(cache_hit_count), 32'd0);
        chk("rst_miss_count", 32'(cache_miss_count), 32'd0);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].do_rst) do_reset();
            do_req(vecs[i].addr, h, b, d, hc, mc);
            chk($sformatf("vec%0d_hit", i), 32'(h), 32'(vecs[i].hit));
            chk($sformatf("vec%0d_bi", i), 32'(b), 32'(vecs[i].bi));
            chk($sformatf("vec%0d_bid", i), d, vecs[i].bid);
            chk($sformatf("vec%0d_hit_count", i), 32'(hc), 32'(vecs[i].hc));
            chk($sformatf("vec%0d_miss_count", i), 32'(mc), 32'(vecs[i].mc));
        end

        // find_start held for 10 cycles: accepts at cycles 0, 4, 8 only.
        do_reset();
        @(negedge clk);
        find_start = 1'b1;
        req_addr   = 32'h0000_1230;
        dones = 0;
        doubles = 0;
        prev = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 9) find_start = 1'b0;
            if (done_L2) begin
                dones++;
                if (prev != 0) doubles++;
            end
            prev = int'(done_L2);
        end
        chk("held_start_accepts", dones, 3);
        chk("held_start_double_done", doubles, 0);
        chk("held_start_miss_count", 32'(cache_miss_count), 32'd1);
        chk("held_start_hit_count", 32'(cache_hit_count), 32'd2);

        // Reset during LOOKUP drops the request and forgets earlier fills.
        do_reset();
        do_req(32'h0000_1230, h, b, d, hc, mc);
        chk("pre_rst_fill_hit", 32'(h), 32'd0);
        @(negedge clk);
        find_start = 1'b1;
        req_addr   = 32'h0000_5550;
        @(negedge clk);
        find_start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done_L2) dones++;
        end
        chk("midop_rst_done", dones, 0);
        chk("midop_rst_busy", 32'(busy), 32'd0);
        chk("midop_rst_hit_count", 32'(cache_hit_count), 32'd0);
        chk("midop_rst_miss_count", 32'(cache_miss_count), 32'd0);
        do_req(32'h0000_1230, h, b, d, hc, mc);
        chk("refetch_after_rst_hit", 32'(h), 32'd0);
        chk("refetch_after_rst_miss_count", 32'(mc), 32'd1);

        do_reset();
        model_clear();
        for (int n = 0; n < 150; n++) begin
            a = ($urandom_range(0, 5) << 14) | ($urandom_range(0, 2) << 4) | $urandom_range(0, 15);
            model_access(a, mh, mb, md);
            do_req(a, h, b, d, hc, mc);
            chk("rand_hit", 32'(h), 32'(mh));
            chk("rand_bi", 32'(b), 32'(mb));
            chk("rand_bid", d, md);
            chk("rand_hit_count", 32'(hc), m_hits);
            chk("rand_miss_count", 32'(mc), m_misses);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_cache_responder.md
L2_CACHE_RESPONDER -- requirements
Module: l2_cache_responder

Interface
REQ-001 SHALL have parameter way, default 4, meaning associativity; power of two, 2 or more.
REQ-002 SHALL have parameter block_size_byte, default 16, meaning line size; offset bits = log2, giving 4 at default.
REQ-003 SHALL have parameter cache_size_byte, default 64*1024, meaning capacity; sets = size/(block*way), giving 1024 sets, 10 index bits [13:4] and 18 tag bits [31:14] at default.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port find_start, input, 1 bit: L1 miss lookup request.
REQ-007 SHALL have port req_addr, input, 32 bits: byte address of the request.
REQ-008 SHALL have port busy, output, 1 bit: high from acceptance until done_L2 inclusive.
REQ-009 SHALL have port L2_cache_hit, output, 1 bit: result, valid while done_L2 is high.
REQ-010 SHALL have port done_L2, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port back_invalidation, output, 1 bit: victim must be removed from L1.
REQ-012 SHALL have port back_invalidation_data, output, 32 bits: victim line address, with offset bits zero.
REQ-013 SHALL have ports cache_hit_count and cache_miss_count, outputs, 20 bits each: statistics.

Function
REQ-014 SHALL accept a request when find_start=1 and busy=0, latching req_addr (cycle T); find_start while busy SHALL be ignored.
REQ-015 SHALL implement FSM IDLE->LOOKUP->UPDATE->RESP->IDLE, one cycle per state, with done_L2 high in RESP at T+3.
REQ-016 LOOKUP SHALL compare the tag against all valid ways of the indexed set in parallel, recording hit and hit_way.
REQ-017 A hit in LOOKUP SHALL increment cache_hit_count; a miss in LOOKUP SHALL increment cache_miss_count; both counters SHALL saturate at 0xFFFFF.
REQ-018 Replacement SHALL be true LRU by position: way 0 = MRU, way (way-1) = LRU.
REQ-019 UPDATE on hit SHALL shift ways 0..hit_way-1 up by one and place the hit line in way 0; a hit in way 0 SHALL leave the set unchanged.
REQ-020 UPDATE on miss SHALL shift all ways up by one, discard way (way-1), and write {valid=1, tag} into way 0.
REQ-021 On a miss with a valid way (way-1) victim, UPDATE SHALL set back_invalidation=1 and back_invalidation_data={victim_tag, index, offset zeros}.
REQ-022 A miss with an invalid victim SHALL leave back_invalidation=0.
REQ-023 back_invalidation and back_invalidation_data SHALL hold stable through RESP until the next request is accepted, then clear to 0.
REQ-024 L2_cache_hit SHALL hold its value until the next acceptance.
REQ-025 Inclusion SHALL hold: every line filled is reported to the requester as a miss, so L1 may fill it.

Reset
REQ-026 rst=1 SHALL force the FSM to IDLE from any state, including mid-operation; the in-flight request SHALL be dropped with no done_L2.
REQ-027 rst=1 SHALL clear all valid bits (kept as a separate flop array) and zero every output and counter.

Structure
REQ-028 Package l2_cache_pkg SHALL hold the FSM state enum, default parameters and derived widths (offset, index, tag, way_width).
REQ-029 Sub-module l2_lru_shift SHALL be combinational: set contents plus hit/miss, hit_way and new tag in, reordered set plus victim line out.

Verification
REQ-030 After reset, a request at 0x00001230 SHALL produce done_L2 at T+3 with L2_cache_hit=0, back_invalidation=0 and cache_miss_count=1.
REQ-031 Repeating 0x00001230 SHALL produce L2_cache_hit=1 and cache_hit_count=1, with cache_miss_count still 1.
REQ-032 Misses at 0x010, 0x4010, 0x8010, 0xC010, then 0x10010 SHALL give back_invalidation=1 with data=0x00000010 only on the fifth access.
REQ-033 After the first four fills, a hit on 0x010 then a miss on 0x10010 SHALL invalidate 0x00004010.
REQ-034 find_start held high for 10 cycles SHALL yield exactly 3 accepted requests (one per 4 cycles), each with done_L2 a single pulse.
REQ-035 rst asserted in LOOKUP SHALL suppress done_L2 and leave counters 0, and re-requesting a previously filled address SHALL miss.
